// File: rtl/lms_pkg.sv
// Shared definitions for the LMS filter and its downstream stages.
//   SAMPLE_W : width of audio / error samples (signed)
//   ACC_W    : width of the filter accumulator output (signed)
//   sat16    : clamp a sign-extended (ACC_W+1)-bit value into SAMPLE_W bits
//   sat16_hit: high when sat16 would clamp that value
package lms_pkg;

  localparam int SAMPLE_W = 16;
  localparam int ACC_W    = 32;

  // Clamp limits, sign-extended to ACC_W+1 bits.
  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W + 1 - SAMPLE_W){1'b0}}, 1'b0, {(SAMPLE_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W + 2 - SAMPLE_W){1'b1}}, {(SAMPLE_W - 1){1'b0}}};

  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [ACC_W:0] v);
    if (v > SAT_MAX) begin
      return SAT_MAX[SAMPLE_W-1:0];
    end else if (v < SAT_MIN) begin
      return SAT_MIN[SAMPLE_W-1:0];
    end
    return v[SAMPLE_W-1:0];
  endfunction

  function automatic logic sat16_hit(input logic signed [ACC_W:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

endpackage

// File: rtl/lms_align_fifo.sv
// Synchronous first-word-fall-through FIFO used to hold desired samples
// until the matching filter output arrives.
//   push/din  : write strobe and data; ignored when full unless popping too
//   pop/dout  : read strobe; dout always shows the head entry
//   level     : occupancy 0..DEPTH
//   full/empty: status flags derived from level
module lms_align_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);
  assign dout  = mem[rd_ptr];

  // A pop frees a slot in the same cycle, so push is allowed when full.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage carries no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/lms_error_align.sv
// Output stage of the LMS filter: rescales and saturates the filter output
// for the DAC and forms the error (desired - output) fed back to the filter.
// Desired samples are queued until the variable-latency filter output for
// the same input sample shows up, keeping the error pairs aligned.
//
// Strobes: in_valid, lms_valid, dac_valid and error_valid are single-cycle
// valid-only qualifiers with no ready/backpressure; data is meaningful only
// in a cycle where its strobe is high, and the outputs hold between strobes.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/desired_in new sample strobe and its desired value
//   lms_valid/lms_out   filter output strobe and 32-bit value
//   clr_flags           clears overflow, underflow, sat_count
//   dac_out/dac_valid   saturated scaled filter output (cycle N+1)
//   error_out/error_valid saturated error (cycle N+2)
//   fifo_level          alignment FIFO occupancy
//   overflow/underflow  sticky FIFO fault flags
//   sat_count           saturating count of clamped samples
module lms_error_align
  import lms_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int FRAC_SHIFT = 15,
  parameter int SAT_CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] desired_in,
  input  logic                       lms_valid,
  input  logic signed [ACC_W-1:0]    lms_out,
  input  logic                       clr_flags,
  output logic signed [SAMPLE_W-1:0] error_out,
  output logic                       error_valid,
  output logic signed [SAMPLE_W-1:0] dac_out,
  output logic                       dac_valid,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow,
  output logic                       underflow,
  output logic [SAT_CNT_W-1:0]       sat_count
);

  logic                       fifo_full;
  logic                       fifo_empty;
  logic [SAMPLE_W-1:0]        fifo_dout;
  logic                       bypass;
  logic                       drop_evt;
  logic                       under_evt;
  logic                       pair_ok;
  logic signed [SAMPLE_W-1:0] pair_desired;
  logic signed [ACC_W-1:0]    y_scaled;
  logic signed [ACC_W:0]      y_ext;
  logic signed [SAMPLE_W:0]   err_diff;
  logic signed [ACC_W:0]      err_ext;
  logic                       err_hit;
  logic                       sat_evt;

  // Stage-1 side registers travelling with dac_out.
  logic signed [SAMPLE_W-1:0] s1_desired;
  logic                       s1_pair_ok;
  logic                       s1_hit;

  // With an empty queue, a desired sample arriving alongside the filter
  // output pairs with it directly and never enters the FIFO.
  assign bypass       = in_valid && lms_valid && fifo_empty;
  assign drop_evt     = in_valid && !lms_valid && fifo_full;
  assign under_evt    = lms_valid && !in_valid && fifo_empty;
  assign pair_ok      = lms_valid && !under_evt;
  assign pair_desired = fifo_empty ? desired_in : fifo_dout;

  lms_align_fifo #(
    .DEPTH (DEPTH),
    .W     (SAMPLE_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid && !bypass),
    .din   (desired_in),
    .pop   (lms_valid),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign y_scaled = lms_out >>> FRAC_SHIFT;
  assign y_ext    = {y_scaled[ACC_W-1], y_scaled};

  // 17-bit difference cannot overflow; only the 16-bit clamp can bite.
  assign err_diff = {s1_desired[SAMPLE_W-1], s1_desired} - {dac_out[SAMPLE_W-1], dac_out};
  assign err_ext  = {{(ACC_W - SAMPLE_W){err_diff[SAMPLE_W]}}, err_diff};
  assign err_hit  = sat16_hit(err_ext);

  // One event per sample, taken when the sample leaves stage 1.
  assign sat_evt = dac_valid && (s1_hit || (s1_pair_ok && err_hit));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dac_out     <= '0;
      dac_valid   <= 1'b0;
      s1_desired  <= '0;
      s1_pair_ok  <= 1'b0;
      s1_hit      <= 1'b0;
      error_out   <= '0;
      error_valid <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      sat_count   <= '0;
    end else begin
      dac_valid <= lms_valid;
      if (lms_valid) begin
        dac_out    <= sat16(y_ext);
        s1_hit     <= sat16_hit(y_ext);
        s1_desired <= pair_desired;
        s1_pair_ok <= pair_ok;
      end

      error_valid <= dac_valid && s1_pair_ok;
      if (dac_valid && s1_pair_ok) begin
        error_out <= sat16(err_ext);
      end

      // A same-cycle event outranks the clear.
      overflow  <= (overflow && !clr_flags) || drop_evt;
      underflow <= (underflow && !clr_flags) || under_evt;
      if (clr_flags) begin
        sat_count <= SAT_CNT_W'(sat_evt);
      end else if (sat_evt && (sat_count != '1)) begin
        sat_count <= sat_count + 1'b1;
      end
    end
  end

endmodule

// File: doc/lms_error_align.md
Name: lms_error_align

Overview:
- Downstream stage of the LMS filter top.
- Consumes the filter's 32-bit output and produces two things:
  - the saturated 16-bit DAC/anti-noise sample;
  - the 16-bit error, computed as desired − output, which is fed back to the filter's error input.
- Buffers each desired sample, which arrives with the input strobe, until the filter's variable-latency output for that sample is valid. This keeps error pairs aligned.

Parameters:
- DEPTH, 4, desired-sample alignment FIFO entries (power of 2, ≥2).
- FRAC_SHIFT, 15, arithmetic right shift applied to the filter output (Q-format rescale).
- SAT_CNT_W, 16, width of the saturation event counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  new-sample strobe; same strobe as the filter input.
- desired_in  in  16  signed desired sample, qualified by in_valid.
- lms_valid  in  1  filter output valid, from the filter out_valid.
- lms_out  in  32  signed filter output, qualified by lms_valid.
- clr_flags  in  1  synchronous clear of overflow, underflow and sat_count.
- error_out  out  16  signed saturated error, held between updates.
- error_valid  out  1  one-cycle pulse when error_out updates.
- dac_out  out  16  signed saturated scaled filter output, held between updates.
- dac_valid  out  1  one-cycle pulse when dac_out updates.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: a push was dropped.
- underflow  out  1  sticky: lms_valid arrived with no desired sample available.
- sat_count  out  SAT_CNT_W  samples with any saturation; saturates at all-ones.

Behaviour:
- Reset: all outputs, FIFO pointers and pipeline registers go to 0 while rst_n=0 at a clk edge. Reset mid-operation discards FIFO contents and in-flight stages, and no valid pulse follows.
- FIFO push: on in_valid. Pop: on lms_valid.
- Push only:
  - Not full: push.
  - Full: drop desired_in, set overflow; level stays DEPTH.
- Push and pop together:
  - Not empty: pop the head and push the new entry; level unchanged. This also applies when full, with no overflow.
  - Empty: bypass. desired_in pairs directly with lms_out; level stays 0; no underflow.
- Pop only, FIFO empty: set underflow. dac path still processes; no error_valid is produced for that sample.
- Stage 1, registered on the lms_valid cycle:
  - y = lms_out >>> FRAC_SHIFT (arithmetic).
  - Clamp y to [-32768, 32767] → dac_out.
  - dac_valid pulses the next cycle.
  - Register the paired desired value and a pair-ok flag.
- Stage 2, one cycle later, only if pair-ok:
  - e = desired − dac_out, evaluated in 17 bits.
  - Clamp e to 16 bits → error_out.
  - error_valid pulses.
- Latency: lms_valid at cycle N → dac_valid at N+1 → error_valid at N+2.
- Fully pipelined: back-to-back lms_valid every cycle is supported.
- sat_count: +1 per sample in which stage 1 or stage 2 clamped, counted once per sample. Holds at max.
- clr_flags:
  - Clears overflow, underflow and sat_count.
  - Events in the same cycle as clr_flags win, so the flag is set and the count is 1.
  - Does not affect FIFO or datapath.

Decomposition:
- Shared package lms_pkg:
  - SAMPLE_W=16, ACC_W=32.
  - Function sat16, which clamps a wider signed value to 16 bits.
  - Shared by this block and the filter core.
- One sub-module, lms_align_fifo: parameterised sync FIFO with level, full/empty, and simultaneous push/pop.
- Scaling, saturation and flag logic stay in the top of this block.

Test Plan:
- Basic pairing:
  - in_valid with desired_in=1000, then 3 cycles later lms_valid with lms_out=32'h0040_0000.
  - Expect dac_out=128 at N+1, error_out=872 at N+2, fifo_level back to 0, sat_count=0.
- Saturation:
  - desired_in=-32768; lms_out=32'h4000_0000, giving y=32768.
  - Expect dac_out=32767, error_out=-32768, sat_count=1.
- Alignment order:
  - Push desired 10, 20, 30 on consecutive in_valid, then three lms_valid with lms_out=0.
  - Expect error_out sequence 10, 20, 30 on consecutive cycles; level 3→0.
- Overflow:
  - DEPTH=4; five in_valid without lms_valid.
  - Expect level=4 and overflow=1; pops return the first four values.
  - Then in_valid and lms_valid together while full: level stays 4, no further drop.
- Underflow and bypass:
  - lms_valid alone on an empty FIFO: underflow=1, dac_valid pulses, no error_valid.
  - Simultaneous in_valid (desired=5) and lms_valid (lms_out=0) on an empty FIFO: error_out=5, level stays 0.
- Reset and clear:
  - Assert rst_n=0 with 2 entries queued and a sample in stage 1.
  - Expect all outputs 0 and no valid pulses after release.
  - clr_flags with underflow=1 and sat_count=3: both clear next cycle.
